i2s_rx_master: RTL
==================

Name: i2s_rx_master

Overview:
- I2S receive master: generates SCLK and LRCK from the system clock CLK, samples serial data_in in the CLK domain and assembles Philips-format stereo frames.
- Delivers each frame as a left/right sample pair over a valid/ready handshake to downstream processing.
- Sequences start and stop of the audio link on frame boundaries and flags samples dropped by backpressure.

Parameters:
RESOLUTION, 24, captured bits per channel, MSB-first; must be <= SLOT_BITS-1
SLOT_BITS, 32, SCLK periods per channel slot; a frame is 2*SLOT_BITS periods
SCLK_DIV, 4, CLK cycles per SCLK half-period; must be >= 2

Ports:
CLK  input  1  system clock; all logic is on its rising edge
RST  input  1  asynchronous, active-high reset
EN  input  1  run request; sampled every CLK
data_in  input  1  serial audio data from the codec; changes after SCLK falls
SCLK  output  1  bit clock, registered
LRCK  output  1  word select, registered; 0 = left slot, 1 = right slot
sample_L  output  RESOLUTION  left sample, held while sample_valid
sample_R  output  RESOLUTION  right sample, held while sample_valid
sample_valid  output  1  sample pair available
sample_ready  input  1  consumer accepts the pair when sample_valid && sample_ready
overrun  output  1  sticky: a completed frame was dropped
busy  output  1  1 while state != IDLE

Behaviour:
- Reset (async, RST=1): all outputs 0. div_cnt=0, bit_cnt=0, state=IDLE, stop_pending=0, shift registers 0.
- States:
  - IDLE: SCLK=0, LRCK=0, counters held at 0. EN=1 -> RUN on the next CLK; overrun is cleared on this transition.
  - RUN: the SCLK generator runs. EN=0 sampled -> STOP.
  - STOP: identical to RUN, but on the falling SCLK event where bit_cnt wraps to 0 -> IDLE. EN=1 sampled in STOP -> back to RUN, with no gap in SCLK.
- SCLK generator (RUN/STOP):
  - div_cnt counts 0..SCLK_DIV-1. At SCLK_DIV-1 it resets and SCLK toggles, so the SCLK period is 2*SCLK_DIV CLK cycles.
  - A toggle 0->1 is a rise event; a toggle 1->0 is a fall event.
- Fall event:
  - bit_cnt = (bit_cnt+1) mod 2*SLOT_BITS.
  - In the same cycle, LRCK <= (new bit_cnt >= SLOT_BITS).
  - LRCK therefore changes with SCLK falling, one period before each slot's MSB.
- Rise event: data_in is sampled in the same CLK cycle as the toggle.
  - Left slot: bit_cnt in 1..RESOLUTION -> shift into shift_L (MSB first).
  - Right slot: bit_cnt in SLOT_BITS+1..SLOT_BITS+RESOLUTION -> shift into shift_R.
  - Bit 0 of each slot (I2S one-bit delay) and bits beyond RESOLUTION are ignored.
- Frame completion happens on the rise event that captures bit_cnt = SLOT_BITS+RESOLUTION.
  - The candidate pair is {shift_L, shift_R including the bit just captured}.
  - Latency: sample_valid rises on the next CLK edge.
- Handshake:
  - If sample_valid=0, or sample_valid && sample_ready in the completion cycle: load sample_L/R, sample_valid=1. No overrun.
  - If sample_valid && !sample_ready at completion: the new pair is discarded, outputs keep the old pair, overrun <= 1.
  - With no completion pending, sample_valid && sample_ready -> sample_valid=0 next cycle; data is unchanged.
  - sample_L/R change only on a load.
- overrun stays set until RST or an IDLE->RUN start.
- Stop granularity: the first frame is always complete. A frame in progress when EN drops finishes, delivers its pair, then SCLK stops low.
- busy = (state != IDLE). busy drops in the cycle IDLE is entered.
- A pending sample_valid in IDLE persists until accepted.
- RST mid-frame: immediate return to the reset state; any partial frame is lost. After release with EN=1, the first frame starts at bit_cnt=0 with LRCK=0.

Test Plan:
- Defaults (frame = 512 CLK). Assert RST=1 with EN=1, then release. While RST=1 -> every output is 0. After release -> busy=1 next cycle; SCLK period = 8 CLK; LRCK low for 256 CLK, then high for 256 CLK.
- Codec model drives L=24'hA5A5A5 and R=24'h5A5A5A in I2S format, sample_ready=1 -> sample_valid is a 1-cycle pulse once per frame with sample_L=24'hA5A5A5 and sample_R=24'h5A5A5A; overrun=0.
- sample_ready=0 across frames L=24'h000001 then L=24'h000002 -> sample_L holds 24'h000001 and overrun=1. Drop and re-raise EN -> overrun returns to 0 at the restart.
- Completion cycle coincides with sample_valid && sample_ready (prior pair pending) -> the new pair loads, sample_valid stays 1, overrun stays 0.
- EN dropped at bit_cnt=10 -> that frame completes and delivers its pair. IDLE is entered at the bit 63->0 fall event; then SCLK=0, LRCK=0, busy=0, and there are no further SCLK edges.
- RST pulsed at bit_cnt=40 with EN=1 -> outputs are 0 immediately. After release, the next sample_valid appears only after a full new frame, carrying the data of that new frame.

Source files
------------

// File: rtl/i2s_rx_master.sv
// rtl/i2s_rx_master.sv - I2S receive master
// Generates SCLK/LRCK from CLK and assembles Philips-format stereo frames.
module i2s_rx_master #(
  parameter int RESOLUTION = 24,
  parameter int SLOT_BITS  = 32,
  parameter int SCLK_DIV   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  data_in,
  output logic                  SCLK,
  output logic                  LRCK,
  output logic [RESOLUTION-1:0] sample_L,
  output logic [RESOLUTION-1:0] sample_R,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  typedef logic [BW-1:0] bit_t;
  typedef logic [DW-1:0] div_t;

  localparam bit_t FRAME_LAST = bit_t'(2 * SLOT_BITS - 1);
  localparam bit_t SLOT_START = bit_t'(SLOT_BITS);
  localparam bit_t L_LAST     = bit_t'(RESOLUTION);
  localparam bit_t R_FIRST    = bit_t'(SLOT_BITS + 1);
  localparam bit_t R_LAST     = bit_t'(SLOT_BITS + RESOLUTION);
  localparam div_t DIV_LAST   = div_t'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state;
  div_t                  div_cnt;
  bit_t                  bit_cnt;
  logic [RESOLUTION-1:0] shift_L;
  logic [RESOLUTION-1:0] shift_R;

  logic                  tick;
  logic                  rise_ev;
  logic                  fall_ev;
  logic                  cap_l;
  logic                  cap_r;
  logic                  complete;
  bit_t                  bit_next;
  logic [RESOLUTION-1:0] shift_l_next;
  logic [RESOLUTION-1:0] shift_r_next;

  always_comb begin
    tick         = (state != IDLE) && (div_cnt == DIV_LAST);
    rise_ev      = tick && !SCLK;
    fall_ev      = tick && SCLK;
    bit_next     = (bit_cnt == FRAME_LAST) ? '0 : bit_cnt + 1'b1;
    // Slot bit 0 is the I2S one-bit delay; bits past RESOLUTION are ignored.
    cap_l        = rise_ev && (bit_cnt != '0) && (bit_cnt <= L_LAST);
    cap_r        = rise_ev && (bit_cnt >= R_FIRST) && (bit_cnt <= R_LAST);
    complete     = rise_ev && (bit_cnt == R_LAST);
    shift_l_next = (shift_L << 1) | {{(RESOLUTION-1){1'b0}}, data_in};
    shift_r_next = (shift_R << 1) | {{(RESOLUTION-1){1'b0}}, data_in};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_L      <= '0;
      shift_R      <= '0;
      SCLK         <= 1'b0;
      LRCK         <= 1'b0;
      sample_L     <= '0;
      sample_R     <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // The completing pair uses the bit captured in this very cycle.
      if (complete) begin
        if (!sample_valid || sample_ready) begin
          sample_L     <= shift_L;
          sample_R     <= shift_r_next;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (cap_l) shift_L <= shift_l_next;
      if (cap_r) shift_R <= shift_r_next;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          SCLK    <= 1'b0;
          LRCK    <= 1'b0;
          if (EN) begin
            state   <= RUN;
            busy    <= 1'b1;
            overrun <= 1'b0;
          end
        end
        RUN, STOP: begin
          state <= EN ? RUN : STOP;
          if (tick) begin
            div_cnt <= '0;
            SCLK    <= !SCLK;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (fall_ev) begin
            bit_cnt <= bit_next;
            LRCK    <= (bit_next >= SLOT_START);
            // A stop only takes effect on the frame wrap, so SCLK ends low.
            if (state == STOP && !EN && bit_next == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
